ray_generator: RTL and testbench

Camera-side ray source for `ray_core`. It walks every pixel of a `IMAGE_W` x `IMAGE_H` frame in raster order. For each pixel it drives one primary ray (camera origin plus an incrementally computed Q8.24 direction) on the `ray_core` input interface: `image_x`, `image_y`, `casted_ray_origin`, `casted_ray_direction`, `new_data`. It honours `stall_source` as back-pressure and sits between the frame controller and `ray_core`.

---
 rtl/ray_pkg.sv | 37 +++
 rtl/ray_vec3_add.sv | 18 +
 rtl/ray_generator.sv | 147 ++++++++++++++
 tb/tb_ray_generator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared widths, lane helpers and FSM encoding for the camera ray source.
// Vectors are packed {z,y,x} with each lane a Q8.24 two's-complement value.
package ray_pkg;

    localparam int LANE_W    = 32;
    localparam int FRAC_BITS = 24;
    localparam int VEC3_W    = 3 * LANE_W;
    localparam int COORD_W   = 11;

    typedef logic [LANE_W-1:0]  lane_t;
    typedef logic [VEC3_W-1:0]  vec3_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic lane_t lane_sel(input vec3_t v, input int idx);
        return v[idx*LANE_W +: LANE_W];
    endfunction

    function automatic lane_t lane_x(input vec3_t v);
        return lane_sel(v, 0);
    endfunction

    function automatic lane_t lane_y(input vec3_t v);
        return lane_sel(v, 1);
    endfunction

    function automatic lane_t lane_z(input vec3_t v);
        return lane_sel(v, 2);
    endfunction

endpackage

// File: rtl/ray_vec3_add.sv
// Combinational three-lane adder; each lane wraps modulo 2^32 with no
// saturation, so lane carries never cross into the neighbouring lane.
module ray_vec3_add
    import ray_pkg::*;
(
    input  vec3_t a,
    input  vec3_t b,
    output vec3_t sum
);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign sum[gi*LANE_W +: LANE_W] = lane_sel(a, gi) + lane_sel(b, gi);
        end
    endgenerate

endmodule

// File: rtl/ray_generator.sv
// Raster-order primary ray source: one ray per pixel, direction stepped
// incrementally from the latched corner by du per column and dv per row.
module ray_generator
    import ray_pkg::*;
#(
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [VEC3_W-1:0]  cam_origin,
    input  logic [VEC3_W-1:0]  cam_corner,
    input  logic [VEC3_W-1:0]  cam_du,
    input  logic [VEC3_W-1:0]  cam_dv,
    input  logic               stall_source,
    output logic [COORD_W-1:0] image_x,
    output logic [COORD_W-1:0] image_y,
    output logic [VEC3_W-1:0]  casted_ray_origin,
    output logic [VEC3_W-1:0]  casted_ray_direction,
    output logic               new_data,
    output logic               busy,
    output logic               frame_done
);

    localparam coord_t X_LAST = coord_t'(IMAGE_W - 1);
    localparam coord_t Y_LAST = coord_t'(IMAGE_H - 1);

    state_t state_reg, state_next;

    coord_t x_reg, y_reg;
    vec3_t  origin_reg, du_reg, dv_reg;
    vec3_t  row_dir_reg, cur_dir_reg;
    vec3_t  cur_plus_du, row_plus_dv;

    coord_t image_x_reg, image_y_reg;
    vec3_t  ray_origin_reg, ray_dir_reg;
    logic   new_data_reg, busy_reg, frame_done_reg;

    logic load, issue, end_of_row, last_pixel;

    assign end_of_row = (x_reg == X_LAST);
    assign last_pixel = end_of_row && (y_reg == Y_LAST);

    ray_vec3_add u_step_x (
        .a   (cur_dir_reg),
        .b   (du_reg),
        .sum (cur_plus_du)
    );

    ray_vec3_add u_step_y (
        .a   (row_dir_reg),
        .b   (dv_reg),
        .sum (row_plus_dv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall_source) begin
                    issue      = 1'b1;
                    state_next = last_pixel ? ST_FINISH : ST_GAP;
                end
            end
            ST_GAP:    state_next = ST_ISSUE;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg          <= '0;
            y_reg          <= '0;
            origin_reg     <= '0;
            du_reg         <= '0;
            dv_reg         <= '0;
            row_dir_reg    <= '0;
            cur_dir_reg    <= '0;
            image_x_reg    <= '0;
            image_y_reg    <= '0;
            ray_origin_reg <= '0;
            ray_dir_reg    <= '0;
            new_data_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            new_data_reg   <= issue;
            frame_done_reg <= (state_reg == ST_FINISH);
            if (state_reg == ST_FINISH) begin
                busy_reg <= 1'b0;
            end
            if (load) begin
                origin_reg  <= cam_origin;
                du_reg      <= cam_du;
                dv_reg      <= cam_dv;
                row_dir_reg <= cam_corner;
                cur_dir_reg <= cam_corner;
                x_reg       <= '0;
                y_reg       <= '0;
                busy_reg    <= 1'b1;
            end
            if (issue) begin
                image_x_reg    <= x_reg;
                image_y_reg    <= y_reg;
                ray_origin_reg <= origin_reg;
                ray_dir_reg    <= cur_dir_reg;
                // Counters stay put on the final pixel so y never passes H-1.
                if (!end_of_row) begin
                    x_reg       <= x_reg + coord_t'(1);
                    cur_dir_reg <= cur_plus_du;
                end else if (!last_pixel) begin
                    x_reg       <= '0;
                    y_reg       <= y_reg + coord_t'(1);
                    row_dir_reg <= row_plus_dv;
                    cur_dir_reg <= row_plus_dv;
                end
            end
        end
    end

    assign image_x              = image_x_reg;
    assign image_y              = image_y_reg;
    assign casted_ray_origin    = ray_origin_reg;
    assign casted_ray_direction = ray_dir_reg;
    assign new_data             = new_data_reg;
    assign busy                 = busy_reg;
    assign frame_done           = frame_done_reg;

endmodule

// File: tb/tb_ray_generator.sv
// Directed bench: a 4x2 frame (ordering, stall, wrap, mid-frame start/reset)
// and a 1x1 frame on a second instance.
module tb_ray_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic        stall = 1'b0;
    logic        stall1 = 1'b0;
    logic [95:0] cam_origin = '0;
    logic [95:0] cam_corner = '0;
    logic [95:0] cam_du = '0;
    logic [95:0] cam_dv = '0;

    logic [10:0] image_x, image_y, image_x1, image_y1;
    logic [95:0] ray_origin, ray_dir, ray_origin1, ray_dir1;
    logic        new_data, busy, frame_done;
    logic        new_data1, busy1, frame_done1;

    int checks = 0;
    int errors = 0;

    localparam logic [95:0] ORIGIN = {32'h00000003, 32'h00000002, 32'h00000001};
    localparam logic [95:0] CORNER = {32'h01000000, 32'hFF800000, 32'hFE800000};
    localparam logic [95:0] DU     = {32'h00000000, 32'h00000000, 32'h01000000};
    localparam logic [95:0] DV     = {32'h00000000, 32'h01000000, 32'h00000000};

    logic [31:0] row_x [4] = '{32'hFE800000, 32'hFF800000, 32'h00800000, 32'h01800000};
    logic [31:0] row_y [2] = '{32'hFF800000, 32'h00800000};

    always #5 clk = ~clk;

    ray_generator #(.IMAGE_W(4), .IMAGE_H(2)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .cam_origin(cam_origin), .cam_corner(cam_corner),
        .cam_du(cam_du), .cam_dv(cam_dv), .stall_source(stall),
        .image_x(image_x), .image_y(image_y),
        .casted_ray_origin(ray_origin), .casted_ray_direction(ray_dir),
        .new_data(new_data), .busy(busy), .frame_done(frame_done)
    );

    ray_generator #(.IMAGE_W(1), .IMAGE_H(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .cam_origin(cam_origin), .cam_corner(cam_corner),
        .cam_du(cam_du), .cam_dv(cam_dv), .stall_source(stall1),
        .image_x(image_x1), .image_y(image_y1),
        .casted_ray_origin(ray_origin1), .casted_ray_direction(ray_dir1),
        .new_data(new_data1), .busy(busy1), .frame_done(frame_done1)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, observed before any clock edge.
        #3;
        check("rst_image_x", image_x, 0);
        check("rst_image_y", image_y, 0);
        check("rst_origin", ray_origin, 0);
        check("rst_dir", ray_dir, 0);
        check("rst_new_data", new_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        step();
        step();
        rst = 1'b0;

        // Frame 1: full 4x2 walk, with a mid-frame start and corner change.
        cam_origin = ORIGIN; cam_corner = CORNER; cam_du = DU; cam_dv = DV;
        start = 1'b1;
        step();
        check("f1_busy_after_start", busy, 1);
        check("f1_no_pulse_yet", new_data, 0);
        start = 1'b0;
        for (int p = 0; p < 8; p++) begin
            step();
            $display("frame1 pulse %0d: x=%0d y=%0d dir=%h", p, image_x, image_y, ray_dir);
            check($sformatf("f1_pulse%0d", p), new_data, 1);
            check($sformatf("f1_x%0d", p), image_x, p % 4);
            check($sformatf("f1_y%0d", p), image_y, p / 4);
            check($sformatf("f1_dir%0d", p), ray_dir, {32'h01000000, row_y[p/4], row_x[p%4]});
            check($sformatf("f1_org%0d", p), ray_origin, ORIGIN);
            if (p == 2) begin
                start = 1'b1;
                cam_corner = {32'h11111111, 32'h22222222, 32'h33333333};
            end
            if (p == 3) start = 1'b0;
            step();
            check($sformatf("f1_gap%0d", p), new_data, 0);
            check($sformatf("f1_hold_x%0d", p), image_x, p % 4);
            if (p < 7) begin
                check($sformatf("f1_busy%0d", p), busy, 1);
                check($sformatf("f1_nodone%0d", p), frame_done, 0);
            end else begin
                check("f1_frame_done", frame_done, 1);
                check("f1_busy_fall", busy, 0);
            end
        end
        step();
        check("f1_done_pulse_end", frame_done, 0);
        check("f1_idle_no_pulse", new_data, 0);
        check("f1_idle_busy", busy, 0);
        cam_corner = CORNER;

        // Frame 2: stall for 10 cycles after the first pulse, then reset mid-frame.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        $display("frame2 pulse 0: x=%0d y=%0d", image_x, image_y);
        check("f2_pulse0", new_data, 1);
        check("f2_x0", image_x, 0);
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("f2_stall%0d", i), new_data, 0);
        end
        stall = 1'b0;
        step();
        $display("frame2 pulse 1: x=%0d y=%0d", image_x, image_y);
        check("f2_pulse1_after_stall", new_data, 1);
        check("f2_x1_after_stall", image_x, 1);
        check("f2_dir1", ray_dir, {32'h01000000, 32'hFF800000, 32'hFF800000});
        step();
        step();
        $display("frame2 pulse 2: x=%0d y=%0d", image_x, image_y);
        check("f2_pulse2", new_data, 1);
        check("f2_x2", image_x, 2);
        #1;
        rst = 1'b1;
        #1;
        check("arst_new_data", new_data, 0);
        check("arst_image_x", image_x, 0);
        check("arst_dir", ray_dir, 0);
        check("arst_origin", ray_origin, 0);
        check("arst_busy", busy, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_rst_no_pulse%0d", i), new_data, 0);
            check($sformatf("post_rst_idle%0d", i), busy, 0);
        end

        // Frame 3: x-lane wraps from 7F000000 to 80000000.
        cam_corner = {32'h01000000, 32'hFF800000, 32'h7F000000};
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        $display("frame3 pulse 0: x=%0d y=%0d dir=%h", image_x, image_y, ray_dir);
        check("f3_pulse0", new_data, 1);
        check("f3_x0", image_x, 0);
        check("f3_y0", image_y, 0);
        check("f3_dir0", ray_dir, {32'h01000000, 32'hFF800000, 32'h7F000000});
        step();
        step();
        $display("frame3 pulse 1: x=%0d y=%0d dir=%h", image_x, image_y, ray_dir);
        check("f3_pulse1", new_data, 1);
        check("f3_wrap_dir", ray_dir, {32'h01000000, 32'hFF800000, 32'h80000000});
        for (int i = 0; i < 40 && !frame_done; i++) step();
        check("f3_frame_done", frame_done, 1);

        // Single-pixel frame on the 1x1 instance.
        start1 = 1'b1;
        step();
        check("s_busy", busy1, 1);
        start1 = 1'b0;
        step();
        $display("single pulse: x=%0d y=%0d dir=%h", image_x1, image_y1, ray_dir1);
        check("s_pulse", new_data1, 1);
        check("s_dir", ray_dir1, {32'h01000000, 32'hFF800000, 32'h7F000000});
        check("s_x", image_x1, 0);
        check("s_y", image_y1, 0);
        step();
        check("s_frame_done", frame_done1, 1);
        check("s_busy_fall", busy1, 0);
        check("s_one_pulse", new_data1, 0);
        step();
        check("s_done_end", frame_done1, 0);
        check("s_no_more", new_data1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
